imm_decode_stage: RTL and testbench

- Registered decode stage directly upstream of the immediate multiplexer in the rysyCore RV32I pipeline.
- Accepts fetched instruction words over a valid/ready handshake and classifies the opcode into an immPkg::imm_type.
- Extracts all five sign-extended immediate formats (J, U, B, S, I).
- Presents them, registered, to the immediate mux and downstream decode/execute logic through a 2-entry skid buffer, so in_ready is a register output with no combinational path from out_ready.

---
 rtl/imm_decode_stage.sv | 140 ++++++++++++++
 tb/tb_imm_decode_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// Immediate-type package and registered RV32I decode stage: classifies the opcode,
// extracts all five immediates and buffers the result through a 2-entry skid buffer.
package immPkg;
  typedef enum logic [2:0] {
    IMM_DEFAULT = 3'd0,
    IMM_I       = 3'd1,
    IMM_S       = 3'd2,
    IMM_B       = 3'd3,
    IMM_U       = 3'd4,
    IMM_J       = 3'd5
  } imm_type;
endpackage

module imm_decode_stage #(
  parameter int REG_LEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [REG_LEN-1:0] in_instr,
  input  logic [REG_LEN-1:0] in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REG_LEN-1:0] out_instr,
  output logic [REG_LEN-1:0] out_pc,
  output immPkg::imm_type    imm_type,
  output logic [REG_LEN-1:0] imm_J,
  output logic [REG_LEN-1:0] imm_U,
  output logic [REG_LEN-1:0] imm_B,
  output logic [REG_LEN-1:0] imm_S,
  output logic [REG_LEN-1:0] imm_I,
  output logic               illegal
);

  typedef struct packed {
    logic [REG_LEN-1:0] instr;
    logic [REG_LEN-1:0] pc;
    logic [REG_LEN-1:0] imm_j;
    logic [REG_LEN-1:0] imm_u;
    logic [REG_LEN-1:0] imm_b;
    logic [REG_LEN-1:0] imm_s;
    logic [REG_LEN-1:0] imm_i;
    immPkg::imm_type    itype;
    logic               illegal;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t  state;
  bundle_t dec;
  bundle_t main_q;
  bundle_t skid_q;

  // Decode the incoming word once so the stored bundle already carries every result.
  always_comb begin
    dec         = '0;
    dec.instr   = in_instr;
    dec.pc      = in_pc;
    dec.imm_i   = {{20{in_instr[31]}}, in_instr[31:20]};
    dec.imm_s   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    dec.imm_b   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
    dec.imm_u   = {in_instr[31:12], 12'b0};
    dec.imm_j   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
    dec.itype   = immPkg::IMM_DEFAULT;
    dec.illegal = 1'b0;
    case (in_instr[6:0])
      7'b1101111:                                     dec.itype = immPkg::IMM_J;
      7'b0110111, 7'b0010111:                         dec.itype = immPkg::IMM_U;
      7'b1100011:                                     dec.itype = immPkg::IMM_B;
      7'b0100011:                                     dec.itype = immPkg::IMM_S;
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: dec.itype = immPkg::IMM_I;
      7'b0110011, 7'b0001111:                         dec.itype = immPkg::IMM_DEFAULT;
      default:                                        dec.illegal = 1'b1;
    endcase
  end

  // Skid-buffer control; in_ready drops only once the skid slot is occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            main_q    <= dec;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (in_valid && out_ready) begin
            main_q <= dec;
          end else if (in_valid) begin
            skid_q   <= dec;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            main_q   <= skid_q;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_instr = main_q.instr;
  assign out_pc    = main_q.pc;
  assign imm_type  = main_q.itype;
  assign imm_J     = main_q.imm_j;
  assign imm_U     = main_q.imm_u;
  assign imm_B     = main_q.imm_b;
  assign imm_S     = main_q.imm_s;
  assign imm_I     = main_q.imm_i;
  assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: directed scenarios plus a random stream
// scored against a FIFO reference model built from the RV32I immediate rules.
module tb_imm_decode_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] j;
    logic [31:0] u;
    logic [31:0] b;
    logic [31:0] s;
    logic [31:0] i;
    logic [2:0]  itype;
    logic        illegal;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [31:0]     in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [31:0]     out_pc;
  immPkg::imm_type imm_type;
  logic [31:0]     imm_J;
  logic [31:0]     imm_U;
  logic [31:0]     imm_B;
  logic [31:0]     imm_S;
  logic [31:0]     imm_I;
  logic            illegal;
  exp_t            got;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  imm_decode_stage #(.REG_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .imm_type(imm_type), .imm_J(imm_J), .imm_U(imm_U), .imm_B(imm_B), .imm_S(imm_S),
    .imm_I(imm_I), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign got = {out_instr, out_pc, imm_J, imm_U, imm_B, imm_S, imm_I, imm_type, illegal};

  // Reference: immediates from field weights with the sign applied by subtraction.
  function automatic exp_t ref_model(logic [31:0] w, logic [31:0] pc);
    exp_t e;
    e.instr   = w;
    e.pc      = pc;
    e.i       = ((w >> 20) & 32'hFFF) - (w[31] ? 32'd4096 : 32'd0);
    e.s       = (((w >> 25) << 5) | ((w >> 7) & 32'd31)) - (w[31] ? 32'd4096 : 32'd0);
    e.b       = ((((w >> 7) & 32'd1) << 11) | (((w >> 25) & 32'd63) << 5) |
                 (((w >> 8) & 32'd15) << 1)) - (w[31] ? 32'd4096 : 32'd0);
    e.u       = w & 32'hFFFFF000;
    e.j       = ((((w >> 12) & 32'd255) << 12) | (((w >> 20) & 32'd1) << 11) |
                 (((w >> 21) & 32'd1023) << 1)) - (w[31] ? 32'h0010_0000 : 32'd0);
    e.illegal = 1'b0;
    case (w[6:0])
      7'h6F:                      e.itype = immPkg::IMM_J;
      7'h37, 7'h17:               e.itype = immPkg::IMM_U;
      7'h63:                      e.itype = immPkg::IMM_B;
      7'h23:                      e.itype = immPkg::IMM_S;
      7'h03, 7'h13, 7'h67, 7'h73: e.itype = immPkg::IMM_I;
      7'h33, 7'h0F:               e.itype = immPkg::IMM_DEFAULT;
      default: begin
        e.itype   = immPkg::IMM_DEFAULT;
        e.illegal = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Advance one clock and update the FIFO model from the handshake it predicts.
  task automatic tick();
    logic in_fire;
    logic out_fire;
    exp_t e;
    in_fire  = in_valid && (q.size() < 2);
    out_fire = out_ready && (q.size() > 0);
    e        = ref_model(in_instr, in_pc);
    @(posedge clk);
    if (!rst_n || flush) q.delete();
    else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) q.push_back(e);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = w;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (imm_type !== immPkg::IMM_DEFAULT) begin errors++; $display("[TB] FAIL reset_imm_type got %0d want IMM_DEFAULT", imm_type); end
    checks++; if ({out_instr, out_pc, imm_J, imm_U, imm_B, imm_S, imm_I, illegal} !== '0) begin
      errors++; $display("[TB] FAIL reset_data got instr %h pc %h immI %h illegal %b want all zero", out_instr, out_pc, imm_I, illegal);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    drive(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %b want 1", out_valid); end
    checks++; if (imm_type !== immPkg::IMM_I) begin errors++; $display("[TB] FAIL single_type got %0d want IMM_I", imm_type); end
    checks++; if (imm_I !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL single_immI got %h want ffffffff", imm_I); end
    checks++; if (out_pc !== 32'h100) begin errors++; $display("[TB] FAIL single_pc got %h want 00000100", out_pc); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL single_illegal got %b want 0", illegal); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4] = '{32'hFFDFF06F, 32'h123452B7, 32'h0020A423, 32'hFE000CE3};
    logic [31:0] imms  [4] = '{32'hFFFFFFFC, 32'h12345000, 32'h00000008, 32'hFFFFFFF8};
    logic [2:0]  types [4] = '{immPkg::IMM_J, immPkg::IMM_U, immPkg::IMM_S, immPkg::IMM_B};
    logic [31:0] sel;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, words[k], 32'h200 + 32'(k * 4), 1'b1, 1'b0);
      tick();
      case (k)
        0:       sel = imm_J;
        1:       sel = imm_U;
        2:       sel = imm_S;
        default: sel = imm_B;
      endcase
      checks++; if (out_valid !== 1'b1 || out_instr !== words[k]) begin
        errors++; $display("[TB] FAIL b2b_word%0d got valid %b instr %h want 1 %h", k, out_valid, out_instr, words[k]);
      end
      checks++; if (imm_type !== types[k] || sel !== imms[k]) begin
        errors++; $display("[TB] FAIL b2b_imm%0d got type %0d imm %h want %0d %h", k, imm_type, sel, types[k], imms[k]);
      end
      checks++; if (q.size() == 0 || got !== q[0]) begin
        errors++; $display("[TB] FAIL b2b_model%0d got %h", k, got);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] words [3] = '{32'h00500113, 32'h00A00193, 32'h00F00213};
    int idx = 0;
    drive(1'b1, words[0], 32'h300, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      if (in_ready && in_valid) idx++;
      tick();
      if (idx < 3) in_instr = words[idx];
      in_pc = 32'h300 + 32'(idx * 4);
      checks++; if (out_instr !== words[0] || out_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL bp_stable%0d got %h valid %b want %h", c, out_instr, out_valid, words[0]);
      end
      checks++; if (in_ready !== (c == 0)) begin
        errors++; $display("[TB] FAIL bp_in_ready%0d got %b want %b", c, in_ready, c == 0);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_instr !== words[1] || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_release got %h ready %b want %h 1", out_instr, in_ready, words[1]);
    end
    tick();
    in_valid = 1'b0;
    checks++; if (out_instr !== words[2] || out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_third got %h valid %b want %h 1", out_instr, out_valid, words[2]);
    end
    tick();
    checks++; if (out_valid !== 1'b0 || q.size() != 0) begin
      errors++; $display("[TB] FAIL bp_drain got valid %b want 0", out_valid);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] words [2] = '{32'h003100B3, 32'h0000007F};
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, words[k], 32'h400, 1'b1, 1'b0);
      tick();
      in_valid = 1'b0;
      checks++; if (imm_type !== immPkg::IMM_DEFAULT || illegal !== (k == 1)) begin
        errors++; $display("[TB] FAIL illegal%0d got type %0d illegal %b want IMM_DEFAULT %b", k, imm_type, illegal, k == 1);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h00100093, 32'h500, 1'b0, 1'b0);
    tick();
    in_instr = 32'h00200093;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_full got ready %b want 0", in_ready); end
    drive(1'b1, 32'hDEADB0B7, 32'h508, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_empty got valid %b ready %b want 0 1", out_valid, in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || out_instr === 32'hDEADB0B7) begin
        errors++; $display("[TB] FAIL flush_ghost%0d got valid %b instr %h want 0", c, out_valid, out_instr);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [14] = '{7'h6F, 7'h37, 7'h17, 7'h63, 7'h23, 7'h03, 7'h13,
                             7'h67, 7'h73, 7'h33, 7'h0F, 7'h7F, 7'h0B, 7'h12};
    logic [31:0] w;
    for (int c = 0; c < 400; c++) begin
      w      = $urandom();
      w[6:0] = ops[$urandom_range(13)];
      drive($urandom_range(3) != 0, w, $urandom(), $urandom_range(2) != 0, $urandom_range(40) == 0);
      checks++; if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        errors++; $display("[TB] FAIL rand_hs%0d got valid %b ready %b want %b %b", c, out_valid, in_ready, q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        checks++; if (got !== q[0]) begin
          errors++; $display("[TB] FAIL rand_data%0d got %h want %h", c, got, q[0]);
        end
      end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h00C00293, 32'h600, 1'b0, 1'b0);
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    q.delete();
    checks++; if (out_valid !== 1'b0 || imm_type !== immPkg::IMM_DEFAULT || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL async_reset got valid %b type %0d ready %b want 0 IMM_DEFAULT 1", out_valid, imm_type, in_ready);
    end
    tick();
    rst_n = 1'b1;
    drive(1'b1, 32'h00000517, 32'h700, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++; if (q.size() == 0 || out_valid !== 1'b1 || got !== q[0]) begin
      errors++; $display("[TB] FAIL async_first got valid %b instr %h want 1 00000517", out_valid, out_instr);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_flush();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
